hanoi_step_sched: RTL and testbench

HANOI_STEP_SCHED -- requirements
Module: hanoi_step_sched

---
 rtl/hanoi_pkg.sv | 18 +
 rtl/hanoi_tick_gen.sv | 35 +++
 rtl/hanoi_step_sched.sv | 120 ++++++++++++
 tb/tb_hanoi_step_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hanoi_pkg.sv
// Shared types and constants for the Hanoi step scheduler.
package hanoi_pkg;

   localparam int CLK_HZ_DEF = 100000000;

   localparam logic [1:0] SPD_1HZ = 2'b00;
   localparam logic [1:0] SPD_2HZ = 2'b01;
   localparam logic [1:0] SPD_5HZ = 2'b10;
   localparam logic [1:0] SPD_MAN = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      REQ   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/hanoi_tick_gen.sv
// 10 Hz prescaler with decade counter and 5 Hz blink; free-running outside reset.
module hanoi_tick_gen
   import hanoi_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF
) (
   input  logic       master_clk,
   input  logic       rst,
   output logic       base_tick,
   output logic [3:0] decade,
   output logic       blink
);

   localparam int DIV   = CLK_HZ / 10;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] base_cnt;

   assign base_tick = (base_cnt == CNT_W'(DIV - 1));

   always_ff @(posedge master_clk) begin
      if (rst) begin
         base_cnt <= '0;
         decade   <= 4'd0;
         blink    <= 1'b0;
      end else if (base_tick) begin
         base_cnt <= '0;
         blink    <= ~blink;
         decade   <= (decade == 4'd9) ? 4'd0 : decade + 4'd1;
      end else begin
         base_cnt <= base_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hanoi_step_sched.sv
// Paces move requests to a Tower-of-Hanoi move engine, automatically or by button.
// Optional acknowledge timeout and ack_err output: define HANOI_ACK_TIMEOUT_EN.
module hanoi_step_sched
   import hanoi_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int MOVE_W = 16
) (
   input  logic              master_clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step_btn,
   input  logic [1:0]        speed_sel,
   input  logic              solved,
   input  logic              move_ack,
   output logic              move_req,
   output logic [MOVE_W-1:0] move_cnt,
   output logic              overrun,
   output logic              blink,
   output logic              done_o
`ifdef HANOI_ACK_TIMEOUT_EN
   ,
   output logic              ack_err
`endif
);

   function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t     state, state_nxt;
   logic       base_tick;
   logic [3:0] decade;
   logic       pace_sel, pace_tick, ack_ok;

   hanoi_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .master_clk (master_clk),
      .rst        (rst),
      .base_tick  (base_tick),
      .decade     (decade),
      .blink      (blink)
   );

   // Speed is decoded combinationally, so a new selection applies at the next base_tick.
   always_comb begin
      pace_sel = 1'b0;
      case (speed_sel)
         SPD_1HZ: pace_sel = (decade == 4'd9);
         SPD_2HZ: pace_sel = (decade == 4'd4) || (decade == 4'd9);
         SPD_5HZ: pace_sel = decade[0];
         default: pace_sel = 1'b0;
      endcase
   end

   assign pace_tick = base_tick & pace_sel;
   assign ack_ok    = move_req & move_ack;

`ifdef HANOI_ACK_TIMEOUT_EN
   logic [9:0] ack_tmr;
   logic       timeout;
   assign timeout = (state == REQ) && !ack_ok && (ack_tmr == 10'h3FF);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (solved)        state_nxt = DONE;
            else if (step_btn) state_nxt = REQ;
            else if (run)      state_nxt = ARMED;
         end
         ARMED: begin
            if (solved)         state_nxt = DONE;
            else if (!run)      state_nxt = IDLE;
            else if (pace_tick) state_nxt = REQ;
         end
         REQ: begin
            // Only the acknowledge (or timeout) may end a handshake.
            if (ack_ok)   state_nxt = solved ? DONE : (run ? ARMED : IDLE);
`ifdef HANOI_ACK_TIMEOUT_EN
            else if (timeout) state_nxt = IDLE;
`endif
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge master_clk) begin
      if (rst) begin
         state    <= IDLE;
         move_req <= 1'b0;
         done_o   <= 1'b0;
         move_cnt <= '0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         move_req <= (state_nxt == REQ);
         done_o   <= (state_nxt == DONE);
         if (ack_ok)
            move_cnt <= sat_inc(move_cnt);
         if (pace_tick && (state == REQ))
            overrun <= 1'b1;
      end
   end

`ifdef HANOI_ACK_TIMEOUT_EN
   always_ff @(posedge master_clk) begin
      if (rst) begin
         ack_tmr <= 10'd0;
         ack_err <= 1'b0;
      end else begin
         ack_tmr <= (state == REQ) ? ack_tmr + 10'd1 : 10'd0;
         if (timeout)
            ack_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hanoi_step_sched.sv
// Directed bench for hanoi_step_sched at CLK_HZ=100 (base_tick every 10 cycles), MOVE_W=4.
module tb_hanoi_step_sched;
   import hanoi_pkg::*;

   logic       master_clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       step_btn = 1'b0;
   logic [1:0] speed_sel = 2'b00;
   logic       solved = 1'b0;
   logic       move_ack = 1'b0;
   logic       move_req;
   logic [3:0] move_cnt;
   logic       overrun;
   logic       blink;
   logic       done_o;
`ifdef HANOI_ACK_TIMEOUT_EN
   logic       ack_err;
`endif

   int vectors = 0;
   int fails   = 0;
   int cyc     = 0;

   always #5 master_clk = ~master_clk;

   hanoi_step_sched #(.CLK_HZ(100), .MOVE_W(4)) dut (
      .master_clk (master_clk),
      .rst        (rst),
      .run        (run),
      .step_btn   (step_btn),
      .speed_sel  (speed_sel),
      .solved     (solved),
      .move_ack   (move_ack),
      .move_req   (move_req),
      .move_cnt   (move_cnt),
      .overrun    (overrun),
      .blink      (blink),
      .done_o     (done_o)
`ifdef HANOI_ACK_TIMEOUT_EN
      ,
      .ack_err    (ack_err)
`endif
   );

   task automatic tick();
      @(posedge master_clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; step_btn = 1'b0; move_ack = 1'b0; solved = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_req(input int budget, output int t);
      int n = 0;
      while (!move_req && n < budget) begin
         tick();
         n++;
      end
      t = cyc;
      chk("req_wait_bound", move_req, 1);
   endtask

   initial begin
      int t, seen, drops;
      logic b;

      // Reset held 3 cycles
      repeat (3) tick();
      chk("rst_move_req", move_req, 0);
      chk("rst_move_cnt", move_cnt, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_blink", blink, 0);
      chk("rst_done", done_o, 0);
      chk("rst_state", dut.state, IDLE);
      rst = 1'b0;
      cyc = 0;

      // 2 Hz auto-stepping, ack three cycles after each request
      run = 1'b1; speed_sel = SPD_2HZ;
      for (int k = 1; k <= 3; k++) begin
         wait_req(60, t);
         chk("req_rise_cycle", t, 50 * k);
         repeat (3) tick();
         move_ack = 1'b1;
         tick();
         move_ack = 1'b0;
         chk("req_fall_after_ack", move_req, 0);
      end
      chk("cnt_after_3", move_cnt, 3);

      // Manual-only pace: step_btn is ignored in ARMED
      speed_sel = SPD_MAN;
      seen = 0;
      repeat (3) begin
         step_btn = 1'b1; tick(); step_btn = 1'b0; tick();
         if (move_req) seen++;
      end
      repeat (100) begin
         tick();
         if (move_req) seen++;
      end
      chk("manual_no_req", seen, 0);
      run = 1'b0;
      tick();
      step_btn = 1'b1;
      chk("step_pre", move_req, 0);
      tick();
      step_btn = 1'b0;
      chk("step_req_next", move_req, 1);
      move_ack = 1'b1; tick(); move_ack = 1'b0;
      chk("step_req_fall", move_req, 0);
      chk("cnt_after_step", move_cnt, 4);
      seen = 0;
      repeat (20) begin
         tick();
         if (move_req) seen++;
      end
      chk("single_step_only", seen, 0);
      move_ack = 1'b1; tick(); move_ack = 1'b0;
      chk("stray_ack_ignored", move_cnt, 4);

      // 5 Hz pace with ack withheld for 60 cycles
      do_reset();
      run = 1'b1; speed_sel = SPD_5HZ;
      wait_req(40, t);
      chk("req5_rise_cycle", t, 20);
      chk("overrun_clear", overrun, 0);
      drops = 0;
      repeat (60) begin
         tick();
         if (!move_req) drops++;
      end
      chk("req_held", drops, 0);
      chk("overrun_set", overrun, 1);
      move_ack = 1'b1; run = 1'b0; tick(); move_ack = 1'b0;
      chk("req5_fall", move_req, 0);
      chk("cnt_overrun", move_cnt, 1);
      seen = 0;
      repeat (30) begin
         tick();
         if (move_req) seen++;
      end
      chk("no_queued_req", seen, 0);
      chk("overrun_sticky", overrun, 1);

      // Reset in the middle of a handshake
      do_reset();
      step_btn = 1'b1; tick(); step_btn = 1'b0;
      chk("mid_req_up", move_req, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_req", move_req, 0);
      chk("mid_rst_cnt", move_cnt, 0);

      // solved raised during REQ
      do_reset();
      step_btn = 1'b1; tick(); step_btn = 1'b0;
      chk("solv_req_up", move_req, 1);
      solved = 1'b1; run = 1'b1; step_btn = 1'b1; speed_sel = SPD_5HZ;
      tick();
      step_btn = 1'b0;
      chk("solv_no_abort", move_req, 1);
      chk("solv_not_done", done_o, 0);
      move_ack = 1'b1; tick(); move_ack = 1'b0;
      chk("solv_cnt", move_cnt, 1);
      chk("solv_done", done_o, 1);
      chk("solv_req_low", move_req, 0);
      seen = 0;
      repeat (120) begin
         tick();
         if (move_req) seen++;
         step_btn = (cyc % 17 == 0);
      end
      step_btn = 1'b0;
      chk("done_no_req", seen, 0);
      chk("done_held", done_o, 1);
      b = blink;
      repeat (10) tick();
      chk("done_blink_runs", blink, !b);

      // MOVE_W=4 saturation after 20 moves
      do_reset();
      repeat (20) begin
         step_btn = 1'b1; tick(); step_btn = 1'b0;
         move_ack = 1'b1; tick(); move_ack = 1'b0;
      end
      chk("cnt_saturate", move_cnt, 15);

`ifdef HANOI_ACK_TIMEOUT_EN
      do_reset();
      step_btn = 1'b1; tick(); step_btn = 1'b0;
      repeat (1023) tick();
      chk("to_req_still_up", move_req, 1);
      chk("to_err_clear", ack_err, 0);
      tick();
      chk("to_req_dropped", move_req, 0);
      chk("to_err_set", ack_err, 1);
      chk("to_state_idle", dut.state, IDLE);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
